// File: rtl/wb_stage_if.sv
// MEM/WB to register-file bundle for the write-back stage.
// master drives the MEM/WB values; slave is the stage that registers them.
interface wb_stage_if #(
  parameter int unsigned word_size = 32,
  parameter int unsigned reg_size  = 5
);
  logic [1:0]           wb_control_signals;
  logic [word_size-1:0] ReadData;
  logic [word_size-1:0] AluResult;
  logic [reg_size-1:0]  destination_reg;
  logic [word_size-1:0] WriteData;
  logic [reg_size-1:0]  WriteReg;
  logic                 RegWriteEn;

  modport master (
    output wb_control_signals,
    output ReadData,
    output AluResult,
    output destination_reg,
    input  WriteData,
    input  WriteReg,
    input  RegWriteEn
  );

  modport slave (
    input  wb_control_signals,
    input  ReadData,
    input  AluResult,
    input  destination_reg,
    output WriteData,
    output WriteReg,
    output RegWriteEn
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: picks load data or ALU result and registers the
// register-file write port one cycle after the MEM/WB inputs.
module wb_stage #(
  parameter int unsigned word_size = 32,
  parameter int unsigned reg_size  = 5
) (
  input logic         clk,
  input logic         reset,
  wb_stage_if.slave   wb
);

  logic [word_size-1:0] write_data_d, write_data_q;
  logic [reg_size-1:0]  write_reg_d,  write_reg_q;
  logic                 reg_write_en_d, reg_write_en_q;

  always_comb begin
    write_data_d   = wb.wb_control_signals[0] ? wb.ReadData : wb.AluResult;
    write_reg_d    = wb.destination_reg;
    // x0 is hard-wired zero, so a write to it is suppressed here.
    reg_write_en_d = wb.wb_control_signals[1] && (wb.destination_reg != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_data_q   <= '0;
      write_reg_q    <= '0;
      reg_write_en_q <= 1'b0;
    end else begin
      write_data_q   <= write_data_d;
      write_reg_q    <= write_reg_d;
      reg_write_en_q <= reg_write_en_d;
    end
  end

  assign wb.WriteData  = write_data_q;
  assign wb.WriteReg   = write_reg_q;
  assign wb.RegWriteEn = reg_write_en_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: mux select, x0 suppression, 1-cycle latency
// and asynchronous reset.
module tb_wb_stage;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  wb_stage_if #(.word_size(32), .reg_size(5)) bus ();

  wb_stage #(.word_size(32), .reg_size(5)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] wd, input logic [4:0] wr,
                           input logic en);
    check({tag, ".WriteData"}, bus.WriteData, wd);
    check({tag, ".WriteReg"}, 32'(bus.WriteReg), 32'(wr));
    check({tag, ".RegWriteEn"}, 32'(bus.RegWriteEn), 32'(en));
  endtask

  task automatic drive(input logic [1:0] ctrl, input logic [31:0] rd, input logic [31:0] ar,
                       input logic [4:0] dr);
    bus.wb_control_signals = ctrl;
    bus.ReadData           = rd;
    bus.AluResult          = ar;
    bus.destination_reg    = dr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(2'b11, 32'h0000_0016, 32'h0000_0014, 5'd2);
    #2;
    check_all("reset_state", 32'h0, 5'd0, 1'b0);

    // Edges while reset is high must not capture.
    tick();
    tick();
    check_all("reset_hold", 32'h0, 5'd0, 1'b0);

    reset = 1'b0;
    drive(2'b00, 32'h0000_0016, 32'h0000_0014, 5'd2);
    #2;
    check_all("no_capture_before_edge", 32'h0, 5'd0, 1'b0);
    tick();
    check_all("ctrl00", 32'h0000_0014, 5'd2, 1'b0);

    drive(2'b01, 32'h0000_0016, 32'h0000_0014, 5'd2);
    tick();
    check_all("ctrl01", 32'h0000_0016, 5'd2, 1'b0);

    drive(2'b10, 32'h0000_0016, 32'h0000_0014, 5'd2);
    tick();
    check_all("ctrl10", 32'h0000_0014, 5'd2, 1'b1);

    drive(2'b11, 32'h0000_0016, 32'h0000_0014, 5'd2);
    tick();
    check_all("ctrl11", 32'h0000_0016, 5'd2, 1'b1);

    drive(2'b10, 32'h0000_0016, 32'h0000_0014, 5'd0);
    tick();
    check_all("x0_write", 32'h0000_0014, 5'd0, 1'b0);

    // Back-to-back values; mid-cycle check shows the previous value still held.
    drive(2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 5'd5);
    #3;
    check_all("lag_hold", 32'h0000_0014, 5'd0, 1'b0);
    tick();
    check_all("b2b_ones", 32'hFFFF_FFFF, 5'd5, 1'b1);

    drive(2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 5'd7);
    tick();
    check_all("b2b_zeros", 32'h0000_0000, 5'd7, 1'b1);

    drive(2'b11, 32'hA5A5_A5A5, 32'h1234_5678, 5'd31);
    tick();
    check_all("ctrl11_r31", 32'hA5A5_A5A5, 5'd31, 1'b1);

    drive(2'b11, 32'h0000_0016, 32'h0000_0014, 5'd3);
    tick();
    check_all("pre_async", 32'h0000_0016, 5'd3, 1'b1);

    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 32'h0, 5'd0, 1'b0);
    tick();
    check_all("async_reset_edge", 32'h0, 5'd0, 1'b0);

    reset = 1'b0;
    drive(2'b10, 32'h0000_0016, 32'h0000_0099, 5'd9);
    #2;
    check_all("post_release_idle", 32'h0, 5'd0, 1'b0);
    tick();
    check_all("post_release_capture", 32'h0000_0099, 5'd9, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage of the 5-stage RISC pipeline. It selects the register-file write value: the memory load data or the ALU result. It forwards the destination register index and produces the register-file write enable. Outputs are registered once, so they present to the register file one clock after the MEM/WB inputs.

Parameters:
word_size, 32, data path width in bits (ReadData, AluResult, WriteData)
reg_size, 5, register index width in bits (destination_reg, WriteReg)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
wb_control_signals  input  2  bit0 = MemtoReg (1 selects ReadData, 0 selects AluResult); bit1 = RegWrite (1 requests register-file write)
ReadData  input  word_size  data loaded from data memory
AluResult  input  word_size  ALU result from the execute stage
destination_reg  input  reg_size  destination register index
WriteData  output  word_size  value to write into the register file
WriteReg  output  reg_size  register index to write
RegWriteEn  output  1  register-file write enable

Behaviour:
- One clock domain, one asynchronous active-high reset.
- Reset asserted: WriteData = 0, WriteReg = 0, RegWriteEn = 0 immediately, independent of clk. These values hold while reset is high.
- First capture after reset deasserts is the next rising clk edge.
- Each rising clk edge with reset low performs these updates:
  - WriteData <= wb_control_signals[0] ? ReadData : AluResult
  - WriteReg <= destination_reg
  - RegWriteEn <= wb_control_signals[1] AND (destination_reg != 0)
- Latency is exactly 1 cycle from input to output. There is no handshake, no stall and no bubble logic. A new input set is accepted every cycle.
- Register 0 is hard-wired zero. A write request to index 0 produces RegWriteEn = 0. WriteData and WriteReg still update normally.
- MemtoReg selects the data regardless of RegWrite. With control 2'b01, WriteData = ReadData and RegWriteEn = 0.
- All data is passed bit-exact. There is no arithmetic, extension or truncation. Widths follow the parameters.
- Control values X or Z are not a legal input. The block performs no X-recovery.
- If reset is asserted in the same cycle as a clk edge, reset wins and the outputs stay 0.

Test Plan:
- reset=1, then release; control 2'b00, ReadData=0x16, AluResult=0x14, destination_reg=2 -> after 1 clk: WriteData=0x14, WriteReg=2, RegWriteEn=0.
- control 2'b01, same data -> next clk: WriteData=0x16, WriteReg=2, RegWriteEn=0.
- control 2'b10, same data -> next clk: WriteData=0x14, WriteReg=2, RegWriteEn=1.
- control 2'b11, same data -> next clk: WriteData=0x16, RegWriteEn=1. Then control 2'b10 with destination_reg=0 -> WriteData=0x14, WriteReg=0, RegWriteEn=0.
- Back-to-back changes every cycle (AluResult 0xFFFFFFFF then 0x00000000, control 2'b10) -> outputs track the inputs with exactly 1-cycle lag and no dropped values.
- Assert reset between clock edges while RegWriteEn=1 and WriteData=0x16 -> all outputs go to 0 immediately with no clk edge. The first clk edge after release captures the current inputs.
